a_if_link: RTL and testbench
============================

// Module: a_if_link
//
// PURPOSE
//  N-lane, 1-bit-per-lane point-to-point link between a source and a sink.
//  Source side drives a long_name bit per lane; sink side reads the same bit per lane.
//  Used where an array of source/sink modport connections is flattened into one block.
//  Optional registered latency; also flags when all sink lanes are set.
//
// PARAMETERS
//  N      4  number of lanes, >=1
//  PARAM  0  link latency in clk cycles; 0 = combinational pass-through, >=1 = register stages
//
// PORTS
//  clk            in   1  sole clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  src_long_name  in   N  source-side bit per lane; bit i = lane i
//  snk_long_name  out  N  sink-side bit per lane; bit i = lane i
//  snk_valid      out  1  sink data reflects source data, pipeline filled since reset
//  snk_all_ones   out  1  AND-reduction of snk_long_name
//
// BEHAVIOUR
//  - Lanes are independent; lane i never affects lane j.
//  - PARAM=0:
//    - snk_long_name = src_long_name, combinational, no storage.
//    - snk_valid = rst_n.
//    - snk_all_ones = &src_long_name.
//  - PARAM>=1: PARAM-deep shift register per lane.
//    - snk_long_name(t) = src_long_name(t-PARAM).
//  - Async reset (rst_n=0), PARAM>=1:
//    - all stages clear to 0 immediately; snk_long_name=0; snk_all_ones=0; snk_valid=0.
//  - Valid tracking, PARAM>=1:
//    - fill counter of width $clog2(PARAM+1) increments after reset release.
//    - Counter saturates at PARAM.
//    - snk_valid=1 once the counter == PARAM, i.e. on the PARAM-th rising edge after release.
//    - snk_valid stays high until the next reset.
//  - snk_all_ones is derived from the sink-side vector, so it has the same latency as the data.
//  - Reset asserted mid-stream: in-flight data is discarded and valid drops.
//    - Refill takes exactly PARAM edges.
//  - No backpressure and no enable: the link samples every clk edge.
//  - Width is exact; no lane wrap, no arithmetic.
//
// STRUCTURE
//  - Package a_if_pkg holds:
//    - localparam N_DEFAULT = 4
//    - typedef logic [N-1:0] lane_vec_t, as a parameterised-width helper
//    - the function all_set(lane_vec_t)
//  - Sub-module a_if_lane_stage: one N-wide flop stage with async active-low clear.
//    - Instantiated PARAM times by a generate loop.
//    - PARAM=0 generates no stages and uses a direct assign.
//  - Fill counter and snk_all_ones live in the top level.
//
// TESTING
//  1. N=4, PARAM=1: reset, then drive src 0,1,2,...,15 on successive edges.
//     -> snk equals src one cycle later.
//     -> snk_all_ones=1 only in the cycle after src=4'hF.
//  2. N=4, PARAM=0: sweep src 0..15.
//     -> snk==src in the same cycle.
//     -> snk_all_ones=1 exactly when src=4'hF.
//     -> snk_valid follows rst_n.
//  3. N=4, PARAM=3: release reset.
//     -> snk_valid=0 for edges 1-2, 1 from edge 3.
//     -> first valid snk equals src sampled at edge 1.
//  4. Lane isolation: src=4'b0101, then 4'b1010.
//     -> snk shows 0101, then 1010; no cross-lane leakage.
//  5. Mid-stream reset, PARAM=2, src=4'hF steady:
//     -> rst_n low between edges clears snk=0, snk_valid=0, snk_all_ones=0 without a clock.
//     -> after release, valid and all_ones return after 2 edges.

Source files
------------

// File: rtl/a_if_link_pkg.sv
// rtl/a_if_link_pkg.sv - shared lane types and helpers for the a_if link
package a_if_pkg;

  localparam int N_DEFAULT = 4;

  // Widest lane count the helpers cover; narrower vectors are zero-padded up to this.
  localparam int LANE_MAX = 64;

  // Width-agnostic lane vector: lane i sits at bit i, unused upper bits are zero.
  typedef logic [LANE_MAX-1:0] lane_vec_t;

  // True when the lowest n lanes of v are all set; upper padding is ignored.
  function automatic logic all_set(lane_vec_t v, int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < LANE_MAX; i++) begin
      if ((i < n) && !v[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/a_if_link_if.sv
// rtl/a_if_link_if.sv - source/sink bundle for the a_if link
interface a_if_link_if
  import a_if_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic [N-1:0] src_long_name;
  logic [N-1:0] snk_long_name;
  logic         snk_valid;
  logic         snk_all_ones;

  // Endpoint view: drives the source lanes, observes the sink side.
  modport master (
    output src_long_name,
    input  snk_long_name,
    input  snk_valid,
    input  snk_all_ones
  );

  // Link view: consumes the source lanes, produces the sink side.
  modport slave (
    input  src_long_name,
    output snk_long_name,
    output snk_valid,
    output snk_all_ones
  );

endinterface

// File: rtl/a_if_link_lane_stage.sv
// rtl/a_if_link_lane_stage.sv - one N-wide lane register stage with async clear
module a_if_lane_stage
  import a_if_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] lane_d;
  logic [N-1:0] lane_q;

  // Next value is simply the upstream lane vector; no enable, every edge samples.
  always_comb begin
    lane_d = d;
  end

  // Lane register, cleared immediately when reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= '0;
    else        lane_q <= lane_d;
  end

  assign q = lane_q;

endmodule

// File: rtl/a_if_link.sv
// rtl/a_if_link.sv - N-lane source-to-sink link with optional register latency
module a_if_link
  import a_if_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int PARAM = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  a_if_link_if.slave link
);

  // Counter only needs to reach PARAM; keep at least one bit so PARAM=0 still elaborates.
  localparam int             CW       = (PARAM > 0) ? $clog2(PARAM + 1) : 1;
  localparam logic [CW-1:0]  FILL_MAX = CW'(PARAM);

  // pipe[0] is the live source; pipe[k] is the source delayed by k edges.
  logic [N-1:0] pipe [PARAM+1];
  lane_vec_t    snk_pad;
  logic [CW-1:0] fill_d;
  logic [CW-1:0] fill_q;

  assign pipe[0] = link.src_long_name;

  for (genvar g = 0; g < PARAM; g++) begin : g_stage
    a_if_lane_stage #(.N(N)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pipe[g]),
      .q     (pipe[g+1])
    );
  end

  assign link.snk_long_name = pipe[PARAM];

  // Fill counter advances once per edge after release and saturates at the pipeline depth.
  always_comb begin
    fill_d = fill_q;
    if (fill_q != FILL_MAX) fill_d = fill_q + CW'(1);
  end

  // Fill counter register; with PARAM=0 it sits at zero, which already equals FILL_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  // Gating with rst_n makes valid drop at once and gives the PARAM=0 case valid = rst_n.
  assign link.snk_valid = rst_n & (fill_q == FILL_MAX);

  // All-ones is taken from the sink vector so it carries the same latency as the data.
  always_comb begin
    snk_pad          = '0;
    snk_pad[N-1:0]   = pipe[PARAM];
  end

  assign link.snk_all_ones = all_set(snk_pad, N);

endmodule

// File: tb/tb_a_if_link.sv
// tb/tb_a_if_link.sv - directed checks of a_if_link at latencies 0, 1, 2 and 3
module tb_a_if_link;

  logic       clk;
  logic       rst_n;
  logic [3:0] src;

  int checks;
  int errors;

  a_if_link_if #(.N(4)) l0 ();
  a_if_link_if #(.N(4)) l1 ();
  a_if_link_if #(.N(4)) l2 ();
  a_if_link_if #(.N(4)) l3 ();

  assign l0.src_long_name = src;
  assign l1.src_long_name = src;
  assign l2.src_long_name = src;
  assign l3.src_long_name = src;

  a_if_link #(.N(4), .PARAM(0)) u_p0 (.clk(clk), .rst_n(rst_n), .link(l0));
  a_if_link #(.N(4), .PARAM(1)) u_p1 (.clk(clk), .rst_n(rst_n), .link(l1));
  a_if_link #(.N(4), .PARAM(2)) u_p2 (.clk(clk), .rst_n(rst_n), .link(l2));
  a_if_link #(.N(4), .PARAM(3)) u_p3 (.clk(clk), .rst_n(rst_n), .link(l3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic [3:0] exp_snk;
    logic       exp_all;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{4'h0, 4'h0, 1'b0};
    vecs[1]  = '{4'h1, 4'h1, 1'b0};
    vecs[2]  = '{4'h2, 4'h2, 1'b0};
    vecs[3]  = '{4'h3, 4'h3, 1'b0};
    vecs[4]  = '{4'h4, 4'h4, 1'b0};
    vecs[5]  = '{4'h5, 4'h5, 1'b0};
    vecs[6]  = '{4'h6, 4'h6, 1'b0};
    vecs[7]  = '{4'h7, 4'h7, 1'b0};
    vecs[8]  = '{4'h8, 4'h8, 1'b0};
    vecs[9]  = '{4'h9, 4'h9, 1'b0};
    vecs[10] = '{4'hA, 4'hA, 1'b0};
    vecs[11] = '{4'hB, 4'hB, 1'b0};
    vecs[12] = '{4'hC, 4'hC, 1'b0};
    vecs[13] = '{4'hD, 4'hD, 1'b0};
    vecs[14] = '{4'hE, 4'hE, 1'b0};
    vecs[15] = '{4'hF, 4'hF, 1'b1};
    vecs[16] = '{4'b0101, 4'b0101, 1'b0};
    vecs[17] = '{4'b1010, 4'b1010, 1'b0};

    // Reset state
    rst_n = 1'b0;
    src   = 4'h0;
    #12;
    chk("rst_p1_snk",   32'(l1.snk_long_name), 32'h0);
    chk("rst_p1_valid", 32'(l1.snk_valid),     32'h0);
    chk("rst_p1_all",   32'(l1.snk_all_ones),  32'h0);
    chk("rst_p0_valid", 32'(l0.snk_valid),     32'h0);
    chk("rst_p3_valid", 32'(l3.snk_valid),     32'h0);
    chk("rst_p2_snk",   32'(l2.snk_long_name), 32'h0);

    // Release between edges; PARAM=0 valid follows rst_n at once
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src   = 4'hA;
    #1;
    chk("rel_p0_valid", 32'(l0.snk_valid), 32'h1);
    chk("rel_p3_valid", 32'(l3.snk_valid), 32'h0);

    edge_wait();  // edge 1 samples 4'hA
    chk("e1_p3_valid", 32'(l3.snk_valid),     32'h0);
    chk("e1_p1_valid", 32'(l1.snk_valid),     32'h1);
    chk("e1_p1_snk",   32'(l1.snk_long_name), 32'hA);
    chk("e1_p2_valid", 32'(l2.snk_valid),     32'h0);
    src = 4'h3;

    edge_wait();  // edge 2
    chk("e2_p3_valid", 32'(l3.snk_valid),     32'h0);
    chk("e2_p2_valid", 32'(l2.snk_valid),     32'h1);
    chk("e2_p2_snk",   32'(l2.snk_long_name), 32'hA);
    src = 4'h5;

    edge_wait();  // edge 3
    chk("e3_p3_valid", 32'(l3.snk_valid),     32'h1);
    chk("e3_p3_snk",   32'(l3.snk_long_name), 32'hA);
    chk("e3_p3_all",   32'(l3.snk_all_ones),  32'h0);

    // Sweep plus lane isolation: PARAM=0 checked same cycle, PARAM=1 after the edge
    for (int i = 0; i < 18; i++) begin
      src = vecs[i].src;
      #2;
      chk($sformatf("p0_snk[%0d]", i),   32'(l0.snk_long_name), 32'(vecs[i].exp_snk));
      chk($sformatf("p0_all[%0d]", i),   32'(l0.snk_all_ones),  32'(vecs[i].exp_all));
      chk($sformatf("p0_valid[%0d]", i), 32'(l0.snk_valid),     32'h1);
      edge_wait();
      chk($sformatf("p1_snk[%0d]", i),   32'(l1.snk_long_name), 32'(vecs[i].exp_snk));
      chk($sformatf("p1_all[%0d]", i),   32'(l1.snk_all_ones),  32'(vecs[i].exp_all));
    end

    // Mid-stream reset with steady all-ones source
    src = 4'hF;
    edge_wait();
    edge_wait();
    edge_wait();
    chk("pre_p2_snk",   32'(l2.snk_long_name), 32'hF);
    chk("pre_p2_valid", 32'(l2.snk_valid),     32'h1);
    chk("pre_p2_all",   32'(l2.snk_all_ones),  32'h1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_p2_snk",   32'(l2.snk_long_name), 32'h0);
    chk("async_p2_valid", 32'(l2.snk_valid),     32'h0);
    chk("async_p2_all",   32'(l2.snk_all_ones),  32'h0);
    chk("async_p0_valid", 32'(l0.snk_valid),     32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    edge_wait();  // refill edge 1
    chk("rf1_p2_valid", 32'(l2.snk_valid),    32'h0);
    chk("rf1_p2_all",   32'(l2.snk_all_ones), 32'h0);
    chk("rf1_p1_snk",   32'(l1.snk_long_name), 32'hF);

    edge_wait();  // refill edge 2
    chk("rf2_p2_valid", 32'(l2.snk_valid),     32'h1);
    chk("rf2_p2_all",   32'(l2.snk_all_ones),  32'h1);
    chk("rf2_p2_snk",   32'(l2.snk_long_name), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
